// File: rtl/payload_tx_serializer.sv
// PSDU payload framer for the 1 Mbps DBPSK transmit path: byte fetch, LSB-first serialisation, optional CRC-32 FCS.
// Build option: define PAYLOAD_TX_FCS_EN to run CRC-32 over the payload and append the 32-bit FCS.
module payload_tx_serializer #(
    parameter int          LEN_W    = 16,
    parameter logic [31:0] CRC_INIT = 32'hFFFFFFFF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_pkt_len,
    input  logic             i_bit_req,
    input  logic [7:0]       i_tx_data,
    input  logic             i_tx_data_valid,
    output logic             o_tx_data_ready,
    output logic             o_tx_bit,
    output logic             o_tx_bit_valid,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err
);

`ifdef PAYLOAD_TX_FCS_EN
    localparam int FCS_BYTES = 4;
    localparam int MIN_LEN   = 40;
    localparam logic [31:0] CRC_POLY = 32'h04C11DB7;

    function automatic logic [31:0] f_crc_step(input logic [31:0] crc, input logic b);
        logic fb;
        fb = crc[31] ^ b;
        return {crc[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
    endfunction
`else
    localparam int FCS_BYTES = 0;
    localparam int MIN_LEN   = 8;
`endif

    typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_FCS} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_buf;
    logic             r_buf_full;
    logic [7:0]       r_shift;
    logic [3:0]       r_shift_cnt;
    logic [LEN_W-4:0] r_fetch_cnt;
    logic [LEN_W-1:0] r_bit_cnt;
    logic [LEN_W-1:0] r_last_pay;
    logic             r_tx_bit;
    logic             r_tx_bit_valid;
    logic             r_done;
    logic             r_err;
`ifdef PAYLOAD_TX_FCS_EN
    logic [31:0]      r_crc;
    logic [LEN_W-1:0] r_len_m1;
`endif

    logic             w_len_ok;
    logic             w_start_ok;
    logic [LEN_W-4:0] w_fetch_init;
    logic             w_accept;
    logic             w_emit;
    logic             w_emit_bit;
    logic             w_load;
    logic             w_pop;
    logic             w_err;
    logic             w_done;

    assign w_len_ok     = (i_pkt_len[2:0] == 3'b000) && (i_pkt_len >= LEN_W'(MIN_LEN));
    assign w_fetch_init = i_pkt_len[LEN_W-1:3] - (LEN_W-3)'(FCS_BYTES);

    assign o_busy          = (r_state != S_IDLE);
    assign o_tx_data_ready = o_busy && !r_buf_full && (r_fetch_cnt != '0);
    assign w_accept        = i_tx_data_valid && o_tx_data_ready;

    assign o_tx_bit       = r_tx_bit;
    assign o_tx_bit_valid = r_tx_bit_valid;
    assign o_done         = r_done;
    assign o_err          = r_err;

    always_comb begin
        w_state_nxt = r_state;
        w_start_ok  = 1'b0;
        w_emit      = 1'b0;
        w_emit_bit  = 1'b0;
        w_load      = 1'b0;
        w_pop       = 1'b0;
        w_err       = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (w_len_ok) begin
                        w_start_ok  = 1'b1;
                        w_state_nxt = S_PAYLOAD;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            S_PAYLOAD: begin
                if (i_bit_req) begin
                    // The prefetched byte is moved into the shifter and its bit 0 sent in the same cycle.
                    if (r_shift_cnt != 4'd0) begin
                        w_emit     = 1'b1;
                        w_emit_bit = r_shift[0];
                        w_pop      = 1'b1;
                    end else if (r_buf_full) begin
                        w_emit     = 1'b1;
                        w_emit_bit = r_buf[0];
                        w_load     = 1'b1;
                    end else begin
                        w_err       = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                    if (w_emit && (r_bit_cnt == r_last_pay)) begin
`ifdef PAYLOAD_TX_FCS_EN
                        w_state_nxt = S_FCS;
`else
                        w_done      = 1'b1;
                        w_state_nxt = S_IDLE;
`endif
                    end
                end
            end
            S_FCS: begin
`ifdef PAYLOAD_TX_FCS_EN
                if (i_bit_req) begin
                    w_emit     = 1'b1;
                    w_emit_bit = ~r_crc[31];
                    if (r_bit_cnt == r_len_m1) begin
                        w_done      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
`else
                w_state_nxt = S_IDLE;
`endif
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_buf_full     <= 1'b0;
            r_shift_cnt    <= 4'd0;
            r_fetch_cnt    <= '0;
            r_bit_cnt      <= '0;
            r_tx_bit       <= 1'b0;
            r_tx_bit_valid <= 1'b0;
            r_done         <= 1'b0;
            r_err          <= 1'b0;
`ifdef PAYLOAD_TX_FCS_EN
            r_crc          <= CRC_INIT;
`endif
        end else begin
            r_state        <= w_state_nxt;
            r_tx_bit_valid <= w_emit;
            r_tx_bit       <= w_emit ? w_emit_bit : 1'b0;
            r_done         <= w_done;
            r_err          <= w_err;
            if (w_start_ok) begin
                r_fetch_cnt <= w_fetch_init;
                r_bit_cnt   <= '0;
                r_buf_full  <= 1'b0;
                r_shift_cnt <= 4'd0;
`ifdef PAYLOAD_TX_FCS_EN
                r_crc       <= CRC_INIT;
`endif
            end else begin
                if (w_accept) begin
                    r_buf_full  <= 1'b1;
                    r_fetch_cnt <= r_fetch_cnt - 1'b1;
                end else if (w_load) begin
                    r_buf_full <= 1'b0;
                end
                if (w_load) begin
                    r_shift_cnt <= 4'd7;
                end else if (w_pop) begin
                    r_shift_cnt <= r_shift_cnt - 4'd1;
                end
                if (w_emit) begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
`ifdef PAYLOAD_TX_FCS_EN
                if (w_emit) begin
                    r_crc <= (r_state == S_PAYLOAD) ? f_crc_step(r_crc, w_emit_bit)
                                                    : {r_crc[30:0], 1'b0};
                end
`endif
            end
        end
    end

    // Data-only registers: contents are qualified by the control flags above.
    always_ff @(posedge clk) begin
        if (w_start_ok) begin
`ifdef PAYLOAD_TX_FCS_EN
            r_last_pay <= i_pkt_len - LEN_W'(33);
            r_len_m1   <= i_pkt_len - LEN_W'(1);
`else
            r_last_pay <= i_pkt_len - LEN_W'(1);
`endif
        end
        if (w_accept) begin
            r_buf <= i_tx_data;
        end
        if (w_load) begin
            r_shift <= {1'b0, r_buf[7:1]};
        end else if (w_pop) begin
            r_shift <= {1'b0, r_shift[7:1]};
        end
    end

endmodule

// File: tb/tb_payload_tx_serializer.sv
// Randomised self-checking bench for payload_tx_serializer against a byte-level CRC-32 reference model.
module tb_payload_tx_serializer;

    localparam int LEN_W = 16;
`ifdef PAYLOAD_TX_FCS_EN
    localparam int FB = 4;
`else
    localparam int FB = 0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             i_start = 1'b0;
    logic [LEN_W-1:0] i_pkt_len = '0;
    logic             i_bit_req = 1'b0;
    logic [7:0]       i_tx_data = 8'h00;
    logic             i_tx_data_valid = 1'b0;
    logic             o_tx_data_ready;
    logic             o_tx_bit;
    logic             o_tx_bit_valid;
    logic             o_busy;
    logic             o_done;
    logic             o_err;

    payload_tx_serializer #(.LEN_W(LEN_W), .CRC_INIT(32'hFFFFFFFF)) dut (
        .clk(clk), .reset(reset), .i_start(i_start), .i_pkt_len(i_pkt_len),
        .i_bit_req(i_bit_req), .i_tx_data(i_tx_data), .i_tx_data_valid(i_tx_data_valid),
        .o_tx_data_ready(o_tx_data_ready), .o_tx_bit(o_tx_bit), .o_tx_bit_valid(o_tx_bit_valid),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    logic [7:0] tx_bytes[$];
    bit   rx_q[$];
    bit   exp_q[$];
    int   done_cnt, err_cnt, lat_bad, ready_seen, busy_seen;
    logic req_last = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) req_last = i_bit_req;

    always @(negedge clk) begin
        if (o_tx_bit_valid) begin
            rx_q.push_back(o_tx_bit);
            if (!req_last) lat_bad++;
        end
        if (o_done) done_cnt++;
        if (o_err) err_cnt++;
        if (o_tx_data_ready) ready_seen++;
        if (o_busy) busy_seen++;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic clear_obs();
        rx_q.delete();
        done_cnt = 0; err_cnt = 0; lat_bad = 0; ready_seen = 0; busy_seen = 0;
    endtask

    // Reference: payload bits LSB-first, then the reflected CRC-32 complement LSB-first.
    task automatic build_expected();
        logic [31:0] crc;
        exp_q.delete();
        crc = 32'hFFFFFFFF;
        foreach (tx_bytes[k]) begin
            for (int b = 0; b < 8; b++) exp_q.push_back(tx_bytes[k][b]);
            crc = crc ^ {24'h0, tx_bytes[k]};
            for (int b = 0; b < 8; b++) crc = crc[0] ? ((crc >> 1) ^ 32'hEDB88320) : (crc >> 1);
        end
        if (FB != 0) begin
            crc = ~crc;
            for (int b = 0; b < 32; b++) exp_q.push_back(crc[b]);
        end
    endtask

    task automatic run_frame(input int gap, input bit rnd, input int max_give,
                             input int abort_bits, input bit extra_start);
        int n, idx, wc, cyc, budget;
        n = tx_bytes.size(); idx = 0; wc = 0; cyc = 0;
        budget = ((n + FB) * 8 + 2) * gap + 200;
        clear_obs();
        @(posedge clk); #1;
        i_pkt_len = LEN_W'((n + FB) * 8);
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        while (1) begin
            i_tx_data_valid = 1'b0;
            if (idx < n && idx < max_give && o_tx_data_ready) begin
                if (!rnd || $urandom_range(0, 1) == 1 || wc >= 3) begin
                    i_tx_data_valid = 1'b1;
                    i_tx_data = tx_bytes[idx];
                    idx++;
                    wc = 0;
                end else begin
                    wc++;
                end
            end
            i_bit_req = (cyc >= 4) && (((cyc - 4) % gap) == 0);
            i_start = extra_start && (cyc == 20);
            if (i_start) i_pkt_len = LEN_W'(44);
            @(posedge clk); #1;
            cyc++;
            if (!o_busy) break;
            if (abort_bits > 0 && rx_q.size() >= abort_bits) break;
            if (cyc > budget) begin
                check("frame_timeout", cyc, budget);
                break;
            end
        end
        i_tx_data_valid = 1'b0;
        i_bit_req = 1'b0;
        i_start = 1'b0;
        if (abort_bits == 0) repeat (2) @(negedge clk);
    endtask

    task automatic compare_stream(input string tag);
        int bad;
        bad = 0;
        check({tag, "_nbits"}, rx_q.size(), exp_q.size());
        foreach (rx_q[k]) if (k < exp_q.size() && rx_q[k] != exp_q[k]) bad++;
        check({tag, "_bits"}, bad, 0);
        check({tag, "_done"}, done_cnt, 1);
        check({tag, "_err"}, err_cnt, 0);
        check({tag, "_latency"}, lat_bad, 0);
    endtask

    task automatic try_bad_len(input string tag, input logic [LEN_W-1:0] len);
        clear_obs();
        @(posedge clk); #1;
        i_pkt_len = len;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        repeat (4) @(negedge clk);
        check({tag, "_err"}, err_cnt, 1);
        check({tag, "_busy"}, busy_seen, 0);
        check({tag, "_ready"}, ready_seen, 0);
    endtask

    initial begin
        logic [31:0] word;
        int bad;
        repeat (3) @(negedge clk);
        check("reset_outputs", {o_busy, o_tx_bit_valid, o_tx_bit, o_tx_data_ready, o_done, o_err}, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // bit_req while idle
        clear_obs();
        i_bit_req = 1'b1;
        repeat (5) @(posedge clk);
        #1 i_bit_req = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_bitreq", rx_q.size() + busy_seen, 0);

        // "123456789" at the nominal bit rate
        tx_bytes.delete();
        for (int k = 0; k < 9; k++) tx_bytes.push_back(8'h31 + 8'(k));
        build_expected();
        run_frame(11, 1'b0, 99, 0, 1'b0);
        compare_stream("ascii");
`ifdef PAYLOAD_TX_FCS_EN
        word = '0;
        for (int b = 0; b < 32; b++) if (72 + b < rx_q.size()) word[b] = rx_q[72 + b];
        check("ascii_fcs", word, 32'hCBF43926);
`endif

        // single byte 0xA5
        tx_bytes.delete();
        tx_bytes.push_back(8'hA5);
        build_expected();
        run_frame(11, 1'b0, 99, 0, 1'b0);
        compare_stream("a5");
        word = '0;
        for (int b = 0; b < 8; b++) if (b < rx_q.size()) word[b] = rx_q[b];
        check("a5_first8", word, 32'h000000A5);

        // illegal lengths
        try_bad_len("len44", LEN_W'(44));
        try_bad_len("len_short", LEN_W'(FB == 4 ? 32 : 0));

        // underrun after the first of three bytes
        tx_bytes.delete();
        for (int k = 0; k < 3; k++) tx_bytes.push_back(8'($urandom));
        build_expected();
        run_frame(11, 1'b0, 1, 0, 1'b0);
        check("underrun_nbits", rx_q.size(), 8);
        bad = 0;
        foreach (rx_q[k]) if (rx_q[k] != exp_q[k]) bad++;
        check("underrun_bits", bad, 0);
        check("underrun_err", err_cnt, 1);
        check("underrun_done", done_cnt, 0);
        check("underrun_busy", o_busy, 0);

        // reset during the tail of a frame, then a fresh minimum frame
        tx_bytes.delete();
        for (int k = 0; k < 4; k++) tx_bytes.push_back(8'($urandom));
        run_frame(11, 1'b0, 99, (FB == 4) ? 37 : 20, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_outputs", {o_busy, o_tx_bit_valid, o_tx_bit, o_tx_data_ready, o_done, o_err}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        tx_bytes.delete();
        tx_bytes.push_back(8'($urandom));
        build_expected();
        run_frame(11, 1'b0, 99, 0, 1'b0);
        compare_stream("after_reset");

        // back-to-back bit_req with random byte availability
        for (int f = 0; f < 4; f++) begin
            tx_bytes.delete();
            for (int k = 0; k < $urandom_range(1, 10); k++) tx_bytes.push_back(8'($urandom));
            build_expected();
            run_frame(1, 1'b1, 99, 0, (f == 0));
            compare_stream($sformatf("stress%0d", f));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
